// File: rtl/tile_map_scanner.sv
// Row-major tile-map walker: for every tile in a (clamped) window it issues a
// memory read of RD_LAT cycles, a load strobe, then holds the tile until the writer accepts it.
module tile_map_scanner #(
   parameter int unsigned COLS   = 28,
   parameter int unsigned ROWS   = 31,
   parameter int unsigned XW     = 5,
   parameter int unsigned YW     = 5,
   parameter int unsigned AW     = 10,
   parameter int unsigned RD_LAT = 1
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Run,
   input  logic          win_en,
   input  logic [XW-1:0] win_x0,
   input  logic [XW-1:0] win_x1,
   input  logic [YW-1:0] win_y0,
   input  logic [YW-1:0] win_y1,
   input  logic          next_tile,
   input  logic          abort,
   output logic          mem_rd_n,
   output logic          ld_reg,
   output logic          write_out,
   output logic          complete,
   output logic          busy,
   output logic [XW-1:0] tile_x,
   output logic [YW-1:0] tile_y,
   output logic [AW-1:0] addr,
   output logic [AW-1:0] tile_idx
);

   localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LOAD,
      S_EMIT,
      S_DONE
   } state_t;

   state_t        state;
   logic [XW-1:0] x0, x1;
   logic [YW-1:0] y0, y1;
   logic [CW-1:0] rd_cnt;

   logic [XW-1:0] sx0, sx1;
   logic [YW-1:0] sy0, sy1;
   logic [AW-1:0] start_addr;
   logic          start_empty;
   logic          last_tile;
   logic [AW-1:0] wrap_addr;

   // Scan bounds as they would be latched by a Run this cycle
   always_comb begin
      sx0 = '0;
      sx1 = X_MAX;
      sy0 = '0;
      sy1 = Y_MAX;
      if (win_en) begin
         sx0 = win_x0;
         sx1 = (win_x1 > X_MAX) ? X_MAX : win_x1;
         sy0 = win_y0;
         sy1 = (win_y1 > Y_MAX) ? Y_MAX : win_y1;
      end
      start_addr  = AW'(sy0) * AW'(COLS) + AW'(sx0);
      start_empty = (sx0 > sx1) || (sy0 > sy1);
   end

   assign last_tile = (tile_x == x1) && (tile_y == y1);
   // Row wrap jumps from column x1 of this row to column x0 of the next
   assign wrap_addr = addr + AW'(COLS) - AW'(x1 - x0);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= S_IDLE;
         x0        <= '0;
         x1        <= '0;
         y0        <= '0;
         y1        <= '0;
         rd_cnt    <= '0;
         mem_rd_n  <= 1'b1;
         ld_reg    <= 1'b0;
         write_out <= 1'b0;
         complete  <= 1'b0;
         busy      <= 1'b0;
         tile_x    <= '0;
         tile_y    <= '0;
         addr      <= '0;
         tile_idx  <= '0;
      end else begin
         ld_reg   <= 1'b0;
         complete <= 1'b0;
         if (abort && (state != S_IDLE)) begin
            state     <= S_IDLE;
            mem_rd_n  <= 1'b1;
            write_out <= 1'b0;
            busy      <= 1'b0;
            tile_x    <= '0;
            tile_y    <= '0;
            addr      <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (Run) begin
                     x0       <= sx0;
                     x1       <= sx1;
                     y0       <= sy0;
                     y1       <= sy1;
                     tile_idx <= '0;
                     busy     <= 1'b1;
                     if (start_empty) begin
                        state    <= S_DONE;
                        complete <= 1'b1;
                        tile_x   <= '0;
                        tile_y   <= '0;
                        addr     <= '0;
                     end else begin
                        state    <= S_READ;
                        mem_rd_n <= 1'b0;
                        rd_cnt   <= '0;
                        tile_x   <= sx0;
                        tile_y   <= sy0;
                        addr     <= start_addr;
                     end
                  end
               end
               S_READ: begin
                  if (rd_cnt == CW'(RD_LAT - 1)) begin
                     state  <= S_LOAD;
                     ld_reg <= 1'b1;
                  end else begin
                     rd_cnt <= rd_cnt + CW'(1);
                  end
               end
               S_LOAD: begin
                  state     <= S_EMIT;
                  mem_rd_n  <= 1'b1;
                  write_out <= 1'b1;
               end
               S_EMIT: begin
                  if (next_tile) begin
                     write_out <= 1'b0;
                     tile_idx  <= tile_idx + AW'(1);
                     if (last_tile) begin
                        state    <= S_DONE;
                        complete <= 1'b1;
                        tile_x   <= '0;
                        tile_y   <= '0;
                        addr     <= '0;
                     end else begin
                        state    <= S_READ;
                        mem_rd_n <= 1'b0;
                        rd_cnt   <= '0;
                        if (tile_x == x1) begin
                           tile_x <= x0;
                           tile_y <= tile_y + YW'(1);
                           addr   <= wrap_addr;
                        end else begin
                           tile_x <= tile_x + XW'(1);
                           addr   <= addr + AW'(1);
                        end
                     end
                  end
               end
               S_DONE: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tile_map_scanner.sv
// Self-checking bench for tile_map_scanner: table of scans on the default board,
// hand-written abort/reset/DONE sequences, and a small board with RD_LAT=3.
module tb_tile_map_scanner;

   logic       clk = 1'b0;
   logic       reset;
   logic       run, win_en, next_tile, abort;
   logic [4:0] win_x0, win_x1, win_y0, win_y1;
   logic       mem_rd_n, ld_reg, write_out, complete, busy;
   logic [4:0] tile_x, tile_y;
   logic [9:0] addr, tile_idx;

   logic       run_b, win_en_b, next_tile_b, abort_b;
   logic [3:0] win_x0_b, win_x1_b;
   logic [1:0] win_y0_b, win_y1_b;
   logic       mem_rd_n_b, ld_reg_b, write_out_b, complete_b, busy_b;
   logic [3:0] tile_x_b;
   logic [1:0] tile_y_b;
   logic [3:0] addr_b, tile_idx_b;

   always #5 clk = ~clk;

   tile_map_scanner dut (
      .Clk(clk), .Reset(reset), .Run(run), .win_en(win_en),
      .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
      .next_tile(next_tile), .abort(abort),
      .mem_rd_n(mem_rd_n), .ld_reg(ld_reg), .write_out(write_out),
      .complete(complete), .busy(busy), .tile_x(tile_x), .tile_y(tile_y),
      .addr(addr), .tile_idx(tile_idx)
   );

   tile_map_scanner #(.COLS(4), .ROWS(2), .XW(4), .YW(2), .AW(4), .RD_LAT(3)) dut_b (
      .Clk(clk), .Reset(reset), .Run(run_b), .win_en(win_en_b),
      .win_x0(win_x0_b), .win_x1(win_x1_b), .win_y0(win_y0_b), .win_y1(win_y1_b),
      .next_tile(next_tile_b), .abort(abort_b),
      .mem_rd_n(mem_rd_n_b), .ld_reg(ld_reg_b), .write_out(write_out_b),
      .complete(complete_b), .busy(busy_b), .tile_x(tile_x_b), .tile_y(tile_y_b),
      .addr(addr_b), .tile_idx(tile_idx_b)
   );

   typedef struct {
      bit en;
      int x0, x1, y0, y1;
      int stall;
      bit pulse_run;
      int exp_n;
   } scan_vec_t;

   typedef struct {
      int x, y, a;
   } tile_t;

   int        n_vec = 0;
   int        n_bad = 0;
   tile_t     sbq[$];
   scan_vec_t vecs[7];

   task automatic chk(input string nm, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input bit en, input int x0, input int x1, input int y0, input int y1);
      win_en = en;
      win_x0 = 5'(x0);
      win_x1 = 5'(x1);
      win_y0 = 5'(y0);
      win_y1 = 5'(y1);
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   task automatic wait_wo(input string nm);
      int n = 0;
      while (!write_out && n < 50) begin
         tick();
         n++;
      end
      chk(nm, int'(write_out), 1);
   endtask

   // One scan on the default board; expected tiles are queued up front and popped on acceptance
   task automatic run_scan(input scan_vec_t v);
      int bx0, bx1, by0, by1, cyc, lds, rdn, wait_cnt;
      bit done_seen;
      tile_t t;
      if (v.en) begin
         bx0 = v.x0; bx1 = (v.x1 > 27) ? 27 : v.x1;
         by0 = v.y0; by1 = (v.y1 > 30) ? 30 : v.y1;
      end else begin
         bx0 = 0; bx1 = 27; by0 = 0; by1 = 30;
      end
      sbq.delete();
      for (int y = by0; y <= by1; y++)
         for (int x = bx0; x <= bx1; x++) begin
            t.x = x; t.y = y; t.a = y * 28 + x;
            sbq.push_back(t);
         end
      next_tile = (v.stall == 0);
      start(v.en, v.x0, v.x1, v.y0, v.y1);
      cyc = 1; lds = 0; rdn = 0; wait_cnt = 0; done_seen = 1'b0;
      while (!done_seen && cyc < 6000) begin
         if (ld_reg) lds++;
         if (!mem_rd_n) rdn++;
         if (v.pulse_run) run = (cyc % 4 == 0);
         if (complete) begin
            done_seen = 1'b1;
         end else if (write_out) begin
            if (sbq.size() == 0) begin
               chk("extra_tile", 1, 0);
               next_tile = 1'b1;
            end else begin
               t = sbq[0];
               chk("tile_x", int'(tile_x), t.x);
               chk("tile_y", int'(tile_y), t.y);
               chk("addr", int'(addr), t.a);
               if (wait_cnt < v.stall) begin
                  next_tile = 1'b0;
                  wait_cnt++;
               end else begin
                  next_tile = 1'b1;
                  void'(sbq.pop_front());
                  wait_cnt = 0;
               end
            end
         end else begin
            next_tile = (v.stall == 0);
         end
         if (!done_seen) begin
            tick();
            cyc++;
         end
      end
      if (!done_seen) begin
         chk("scan_timeout", 0, 1);
      end else begin
         chk("idx_at_complete", int'(tile_idx), v.exp_n);
         chk("complete_cycle", cyc, v.exp_n * (3 + v.stall) + 1);
         chk("ld_pulses", lds, v.exp_n);
         chk("rd_low_cycles", rdn, 2 * v.exp_n);
         chk("tiles_left", sbq.size(), 0);
         chk("done_x", int'(tile_x), 0);
         chk("done_addr", int'(addr), 0);
         chk("done_busy", int'(busy), 1);
      end
      tick();
      run = 1'b0;
      next_tile = 1'b0;
      chk("busy_after", int'(busy), 0);
      chk("complete_once", int'(complete), 0);
      tick();
   endtask

   initial begin
      int cyc, k, lds, rdn, pulses;
      bit seen;

      vecs[0] = '{en: 0, x0: 9,  x1: 1,  y0: 7,  y1: 2,  stall: 0, pulse_run: 0, exp_n: 868};
      vecs[1] = '{en: 1, x0: 3,  x1: 5,  y0: 10, y1: 11, stall: 0, pulse_run: 0, exp_n: 6};
      vecs[2] = '{en: 1, x0: 6,  x1: 2,  y0: 0,  y1: 0,  stall: 0, pulse_run: 0, exp_n: 0};
      vecs[3] = '{en: 1, x0: 0,  x1: 1,  y0: 5,  y1: 5,  stall: 5, pulse_run: 1, exp_n: 2};
      vecs[4] = '{en: 1, x0: 25, x1: 31, y0: 29, y1: 31, stall: 0, pulse_run: 0, exp_n: 6};
      vecs[5] = '{en: 1, x0: 27, x1: 27, y0: 30, y1: 30, stall: 1, pulse_run: 1, exp_n: 1};
      vecs[6] = '{en: 1, x0: 0,  x1: 3,  y0: 5,  y1: 4,  stall: 0, pulse_run: 0, exp_n: 0};

      reset = 1'b1; run = 0; win_en = 0; next_tile = 0; abort = 0;
      win_x0 = 0; win_x1 = 0; win_y0 = 0; win_y1 = 0;
      run_b = 0; win_en_b = 0; next_tile_b = 0; abort_b = 0;
      win_x0_b = 0; win_x1_b = 0; win_y0_b = 0; win_y1_b = 0;
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_mem_rd_n", int'(mem_rd_n), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_write_out", int'(write_out), 0);
      chk("rst_ld_reg", int'(ld_reg), 0);
      chk("rst_complete", int'(complete), 0);
      chk("rst_addr", int'(addr), 0);
      chk("rst_idx", int'(tile_idx), 0);
      chk("rst_b_mem_rd_n", int'(mem_rd_n_b), 1);
      chk("rst_b_busy", int'(busy_b), 0);

      foreach (vecs[i]) run_scan(vecs[i]);

      // Abort together with next_tile on the second tile
      start(1, 0, 3, 0, 0);
      wait_wo("abort_first_emit");
      next_tile = 1'b1;
      tick();
      next_tile = 1'b0;
      wait_wo("abort_second_emit");
      abort = 1'b1;
      next_tile = 1'b1;
      tick();
      abort = 1'b0;
      next_tile = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_write_out", int'(write_out), 0);
      chk("abort_idx", int'(tile_idx), 1);
      chk("abort_x", int'(tile_x), 0);
      chk("abort_addr", int'(addr), 0);
      chk("abort_mem_rd_n", int'(mem_rd_n), 1);
      pulses = int'(complete);
      for (int i = 0; i < 5; i++) begin
         tick();
         pulses += int'(complete);
      end
      chk("abort_no_complete", pulses, 0);

      // Abort during the read phase
      start(1, 1, 2, 1, 1);
      chk("rd_phase_low", int'(mem_rd_n), 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_rd_busy", int'(busy), 0);
      chk("abort_rd_mem", int'(mem_rd_n), 1);

      // Reset mid-scan clears the tile count
      start(1, 2, 4, 1, 1);
      wait_wo("rst_mid_emit");
      next_tile = 1'b1;
      tick();
      next_tile = 1'b0;
      chk("rst_mid_idx_before", int'(tile_idx), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_idx", int'(tile_idx), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_mem", int'(mem_rd_n), 1);
      chk("rst_mid_x", int'(tile_x), 0);
      tick();

      // Empty window, then Run held during DONE must be ignored
      start(1, 6, 2, 0, 0);
      chk("empty_complete", int'(complete), 1);
      chk("empty_busy", int'(busy), 1);
      chk("empty_mem", int'(mem_rd_n), 1);
      win_x0 = 0; win_x1 = 0;
      run = 1'b1;
      tick();
      run = 1'b0;
      chk("done_run_busy", int'(busy), 0);
      chk("done_run_mem", int'(mem_rd_n), 1);
      tick();
      chk("done_run_idle", int'(busy), 0);

      // Small board, RD_LAT=3, x1 clamped from 9 to 3
      win_en_b = 1; win_x0_b = 0; win_x1_b = 4'd9; win_y0_b = 0; win_y1_b = 2'd1;
      next_tile_b = 1'b1;
      run_b = 1'b1;
      tick();
      run_b = 1'b0;
      cyc = 1; k = 0; lds = 0; rdn = 0; seen = 1'b0;
      while (!seen && cyc < 500) begin
         if (ld_reg_b) lds++;
         if (!mem_rd_n_b) rdn++;
         if (complete_b) begin
            seen = 1'b1;
         end else begin
            if (write_out_b) begin
               chk("b_tile_x", int'(tile_x_b), k % 4);
               chk("b_tile_y", int'(tile_y_b), k / 4);
               chk("b_addr", int'(addr_b), k);
               k++;
            end
            tick();
            cyc++;
         end
      end
      chk("b_complete_seen", int'(seen), 1);
      chk("b_idx", int'(tile_idx_b), 8);
      chk("b_cycle", cyc, 8 * 5 + 1);
      chk("b_ld_pulses", lds, 8);
      chk("b_rd_low", rdn, 32);
      chk("b_tiles", k, 8);
      next_tile_b = 1'b0;
      tick();
      chk("b_busy_after", int'(busy_b), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/tile_map_scanner.md
# tile_map_scanner

Parametrised tile-map walker that steps a rectangular window of a COLS x ROWS game board in row-major order. For each tile it runs a memory read phase and a register-load strobe, then holds the tile for the video writer until the writer requests the next one. It sits between the game-board RAM and the sprite/video writer and is the general successor to the fixed 28x31 board reader: board size is configurable, sub-window scans are supported, the tile count is exact, read latency is programmable, and scans can be aborted.

## Interface
- COLS, 28, tiles per row (>=1)
- ROWS, 31, rows per board (>=1)
- XW, 5, tile_x width; must hold COLS-1
- YW, 5, tile_y width; must hold ROWS-1
- AW, 10, linear address width; must hold COLS*ROWS-1
- RD_LAT, 1, memory read cycles before the load strobe (>=1)

Ports:
- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  reset, synchronous, active-high
- Run  in  1  start request; sampled only in IDLE
- win_en  in  1  at Run: 1 = scan window, 0 = scan full board
- win_x0, win_x1  in  XW  inclusive column bounds, latched at Run
- win_y0, win_y1  in  YW  inclusive row bounds, latched at Run
- next_tile  in  1  writer accepts current tile; honoured only in EMIT
- abort  in  1  terminate scan
- mem_rd_n  out  1  active-low memory access
- ld_reg  out  1  one-cycle load strobe for the tile data register
- write_out  out  1  tile valid to writer
- complete  out  1  one-cycle pulse at the end of a scan
- busy  out  1  high in every state except IDLE
- tile_x  out  XW  current column
- tile_y  out  YW  current row
- addr  out  AW  registered linear address, tile_y*COLS + tile_x
- tile_idx  out  AW  tiles accepted so far in this scan

## Operation
- States: IDLE, READ, LOAD, EMIT, DONE.
- Reset puts the block in IDLE. All outputs are 0 except mem_rd_n = 1.
- IDLE:
  - On Run, latch bounds and clear tile_idx.
  - If win_en = 0, bounds are 0..COLS-1 and 0..ROWS-1.
  - If win_en = 1, clamp x1 to COLS-1 and y1 to ROWS-1.
  - Load tile_x = x0, tile_y = y0, and addr accordingly.
  - If x0 > x1 or y0 > y1 after clamping, go to DONE (empty scan, no reads). Otherwise go to READ.
- READ: mem_rd_n = 0 for exactly RD_LAT cycles (internal counter), then LOAD.
- LOAD: mem_rd_n = 0 and ld_reg = 1 for one cycle, then EMIT.
- EMIT:
  - write_out = 1; hold tile_x, tile_y, addr until next_tile.
  - On next_tile at the last tile (tile_x = x1 and tile_y = y1): increment tile_idx, go to DONE.
  - On next_tile at any other tile: increment tile_idx and advance, then go to READ.
  - Advance rule: if tile_x = x1, set tile_x = x0 and tile_y + 1. Otherwise tile_x + 1.
  - addr tracks the advance: +1 in-row; on row wrap, + (COLS - (x1 - x0)).
- DONE: complete = 1 for one cycle. Coordinates and addr return to 0; tile_idx holds the final count. Next state is IDLE.
- abort in any non-IDLE state: next state is IDLE, no complete pulse, coordinates and addr cleared. abort takes priority over next_tile.
- Run outside IDLE is ignored. Run in the DONE cycle is ignored.
- Reset mid-scan behaves as abort and also clears tile_idx.

## Timing
- Run sampled high in IDLE at cycle 0:
  - READ occupies cycles 1..RD_LAT.
  - LOAD occurs at cycle RD_LAT+1.
  - EMIT starts at cycle RD_LAT+2.
- tile_x, tile_y and addr are valid from READ entry through EMIT exit.
- Minimum per-tile period is RD_LAT+2 cycles (next_tile asserted on the first EMIT cycle).
- complete is asserted in the cycle after the final next_tile. busy falls in the cycle after that.
- An empty window produces complete at cycle 1 with no mem_rd_n or ld_reg activity.

## Test plan
- Default params, RD_LAT=1, win_en=0, next_tile held high: exactly 868 ld_reg pulses; last tile at (27,30) with addr=867; tile_idx=868 at complete; each tile takes 3 cycles.
- Window x 3..5, y 10..11: tile order (3,10),(4,10),(5,10),(3,11),(4,11),(5,11); addr sequence 283,284,285,311,312,313; tile_idx=6.
- Window x0=6, x1=2: complete at cycle 1; mem_rd_n stays 1; busy high for one cycle only.
- next_tile withheld 5 cycles in EMIT: write_out and coordinates stable for those cycles; pulsing Run during the scan has no effect.
- abort asserted in EMIT together with next_tile: back in IDLE next cycle, no complete pulse, tile_idx unchanged.
- RD_LAT=3, COLS=4, ROWS=2, window x1=9 (clamped to 3): 8 tiles; mem_rd_n low for 4 cycles per tile.
